// File: rtl/glitch_response_monitor.sv
// Glitch response monitor: times and counts target rising edges in a window after each glitch.
// Optional macro STICKY_FAULT_EN makes LEDG[1] latch on any fault/timeout report until RESET.
module glitch_response_monitor #(
  parameter int unsigned WINDOW_UNIT  = 100000,
  parameter int unsigned EXPECT_EDGES = 1,
  parameter int unsigned HOLDOFF      = 10000000
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        GLITCH_IN,
  input  logic        TARGET_IN,
  input  logic [9:0]  SW,
  output logic [1:0]  RESULT,
  output logic [26:0] LATENCY,
  output logic [7:0]  EDGES,
  output logic        DONE,
  output logic [1:0]  LEDG
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StObserve  = 2'd1,
    StReport   = 2'd2,
    StCooldown = 2'd3
  } state_e;

  localparam logic [26:0] UnitW = 27'(WINDOW_UNIT);

  state_e      state_q, state_d;
  logic        tgt_meta_q, tgt_sync_q, tgt_prev_q;
  logic        glitch_q;
  logic        tgt_rise, glitch_rise;

  logic [26:0] window_q, window_d;
  logic [26:0] cycle_q, cycle_d;
  logic [7:0]  edges_q, edges_d;
  logic        first_q, first_d;
  logic [26:0] lat_q, lat_d;
  logic [31:0] hold_q, hold_d;

  logic [1:0]  result_q, result_d;
  logic [26:0] latency_q, latency_d;
  logic [7:0]  edges_out_q, edges_out_d;
  logic        done_q, done_d;

  logic [9:0]  sw_eff;
  logic [26:0] window_calc;
  logic [7:0]  edges_inc;
  logic [26:0] lat_next;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      tgt_meta_q <= 1'b0;
      tgt_sync_q <= 1'b0;
      tgt_prev_q <= 1'b0;
      glitch_q   <= 1'b0;
    end else begin
      tgt_meta_q <= TARGET_IN;
      tgt_sync_q <= tgt_meta_q;
      tgt_prev_q <= tgt_sync_q;
      glitch_q   <= GLITCH_IN;
    end
  end

  assign tgt_rise    = tgt_sync_q & ~tgt_prev_q;
  assign glitch_rise = GLITCH_IN & ~glitch_q;

  assign sw_eff      = (SW == 10'd0) ? 10'd1 : SW;
  assign window_calc = {17'd0, sw_eff} * UnitW;

  // Edge count/latency including an edge landing in the current cycle, so the
  // final window cycle contributes to the report.
  assign edges_inc = (tgt_rise && (edges_q != 8'hFF)) ? edges_q + 8'd1 : edges_q;
  assign lat_next  = (tgt_rise && !first_q) ? cycle_q : lat_q;

  always_comb begin
    state_d     = state_q;
    window_d    = window_q;
    cycle_d     = cycle_q;
    edges_d     = edges_q;
    first_d     = first_q;
    lat_d       = lat_q;
    hold_d      = hold_q;
    result_d    = result_q;
    latency_d   = latency_q;
    edges_out_d = edges_out_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (glitch_rise) begin
          state_d  = StObserve;
          window_d = window_calc;
          cycle_d  = '0;
          edges_d  = '0;
          first_d  = 1'b0;
          lat_d    = '0;
        end
      end
      StObserve: begin
        edges_d = edges_inc;
        lat_d   = lat_next;
        first_d = first_q | tgt_rise;
        if (cycle_q == window_q - 27'd1) begin
          state_d     = StReport;
          edges_out_d = edges_inc;
          done_d      = 1'b1;
          if (edges_inc == 8'd0) begin
            result_d  = 2'b11;
            latency_d = '0;
          end else begin
            result_d  = (32'(edges_inc) == EXPECT_EDGES) ? 2'b01 : 2'b10;
            latency_d = lat_next;
          end
        end else begin
          cycle_d = cycle_q + 27'd1;
        end
      end
      StReport: begin
        state_d = StCooldown;
        hold_d  = '0;
      end
      StCooldown: begin
        // HOLDOFF of 0 behaves as a single cooldown cycle.
        if (hold_q + 32'd1 >= HOLDOFF) begin
          state_d = StIdle;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      window_q    <= '0;
      cycle_q     <= '0;
      edges_q     <= '0;
      first_q     <= 1'b0;
      lat_q       <= '0;
      hold_q      <= '0;
      result_q    <= 2'b00;
      latency_q   <= '0;
      edges_out_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      window_q    <= window_d;
      cycle_q     <= cycle_d;
      edges_q     <= edges_d;
      first_q     <= first_d;
      lat_q       <= lat_d;
      hold_q      <= hold_d;
      result_q    <= result_d;
      latency_q   <= latency_d;
      edges_out_q <= edges_out_d;
      done_q      <= done_d;
    end
  end

`ifdef STICKY_FAULT_EN
  logic fault_q;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      fault_q <= 1'b0;
    end else if (done_d && result_d[1]) begin
      fault_q <= 1'b1;
    end
  end

  assign LEDG[1] = fault_q;
`else
  assign LEDG[1] = result_q[1];
`endif

  assign LEDG[0] = (result_q == 2'b01);
  assign RESULT  = result_q;
  assign LATENCY = latency_q;
  assign EDGES   = edges_out_q;
  assign DONE    = done_q;

endmodule

// File: doc/glitch_response_monitor.md
GLITCH_RESPONSE_MONITOR -- requirements
Module: glitch_response_monitor

Interface
REQ-001 Parameter WINDOW_UNIT, default 100000: clock cycles per SW count in the observation window.
REQ-002 Parameter EXPECT_EDGES, default 1: number of target rising edges a healthy target produces in the window.
REQ-003 Parameter HOLDOFF, default 10000000: cooldown cycles after each report.
REQ-004 CLOCK_50  input  1  sole clock, 50 MHz.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 GLITCH_IN  input  1  glitch strobe from the injector, synchronous to CLOCK_50; its rising edge starts an observation.
REQ-007 TARGET_IN  input  1  target status pin, asynchronous to CLOCK_50.
REQ-008 SW  input  10  observation window length in WINDOW_UNIT steps.
REQ-009 RESULT  output  2  outcome: 00 none, 01 normal, 10 fault, 11 timeout.
REQ-010 LATENCY  output  27  cycles from window start to the first target rising edge.
REQ-011 EDGES  output  8  target rising edges counted in the last window.
REQ-012 DONE  output  1  one-cycle pulse when RESULT, LATENCY and EDGES update.
REQ-013 LEDG  output  2  LEDG[0] = last result normal; LEDG[1] = fault indicator.

Function
REQ-014 TARGET_IN shall pass through a 2-flop synchronizer; a rising edge is synchronized value 1 with the previous synchronized value 0.
REQ-015 A GLITCH_IN rising edge is the registered GLITCH_IN at 0 followed by GLITCH_IN at 1.
REQ-016 States: IDLE, OBSERVE, REPORT, COOLDOWN. Encoding values outside these four shall go to IDLE.
REQ-017 IDLE -> OBSERVE on a GLITCH_IN rising edge. On entry: latch window = max(SW,1)*WINDOW_UNIT (27-bit product), clear cycle counter, edge counter and first-edge flag.
REQ-018 In OBSERVE, the cycle counter starts at 0 in the first OBSERVE cycle and increments by 1 per cycle.
REQ-019 The first target rising edge in OBSERVE shall capture the current cycle counter into an internal latency register.
REQ-020 The edge counter shall saturate at 255.
REQ-021 OBSERVE -> REPORT when the cycle counter equals window-1. A target edge in that same cycle shall be counted.
REQ-022 Classification in REPORT: edges==0 -> 11; edges==EXPECT_EDGES -> 01; otherwise -> 10.
REQ-023 In the REPORT cycle, RESULT, EDGES and LATENCY shall be registered, with LATENCY set to 0 when edges==0. DONE shall be 1 for exactly that cycle.
REQ-024 REPORT -> COOLDOWN always. COOLDOWN lasts HOLDOFF cycles, then -> IDLE.
REQ-025 GLITCH_IN edges in OBSERVE, REPORT or COOLDOWN shall be ignored and not queued.
REQ-026 A change to SW during OBSERVE shall have no effect until the next observation.
REQ-027 LEDG[0] = (RESULT==01). LEDG[1] = (RESULT==10 or RESULT==11) unless REQ-031 applies.
REQ-028 Outputs shall hold their values between reports.

Reset
REQ-029 RESET high shall immediately force IDLE, clear the synchronizer, all counters and edge-detect registers, and set RESULT=00, LATENCY=0, EDGES=0, DONE=0, LEDG=00.
REQ-030 RESET asserted mid-OBSERVE shall abort the window with no DONE pulse; a GLITCH_IN edge is required after release to re-arm.

Configuration
REQ-031 Macro STICKY_FAULT_EN defined: LEDG[1] shall latch 1 on any fault or timeout report and clear only on RESET. Macro undefined: LEDG[1] shall follow REQ-027 and clear on the next normal report.

Verification
REQ-032 WINDOW_UNIT=10, SW=5, EXPECT_EDGES=1; glitch, then one TARGET_IN rise landing synchronized at OBSERVE cycle 7 -> DONE at window end, RESULT=01, EDGES=1, LATENCY=7, LEDG=01.
REQ-033 Same setup, no TARGET_IN activity -> RESULT=11, EDGES=0, LATENCY=0, LEDG[1]=1.
REQ-034 Same setup, three target rises in the window -> RESULT=10, EDGES=3; a second glitch during COOLDOWN produces no DONE.
REQ-035 SW=0 -> window of 10 cycles (treated as SW=1); an edge synchronized in OBSERVE cycle 9 is counted, giving RESULT=01.
REQ-036 RESET pulsed during OBSERVE -> all outputs 0, no DONE; with STICKY_FAULT_EN, a fault then a normal report -> LEDG=11; without the macro -> LEDG=01.
